// File: rtl/nthband_error_quantizer_if.sv
// Stream bundle between the nth-band predictor, the error quantizer and the entropy coder.
// The slave view belongs to the quantizer; the master view belongs to its environment.
interface nthband_error_quantizer_if #(
   parameter int DATA_WIDTH  = 16,
   parameter int SHIFT_WIDTH = 4
);
   logic [SHIFT_WIDTH-1:0]       quant_shift;
   logic                         x_valid;
   logic                         x_ready;
   logic [DATA_WIDTH-1:0]        x_data;
   logic                         prediction_valid;
   logic                         prediction_ready;
   logic signed [DATA_WIDTH:0]   prediction_data;
   logic                         qerr_valid;
   logic                         qerr_ready;
   logic signed [DATA_WIDTH+1:0] qerr_data;
   logic                         qerr_last;
   logic                         xhat_valid;
   logic                         xhat_ready;
   logic [DATA_WIDTH-1:0]        xhat_data;

   modport master (
      output quant_shift, x_valid, x_data, prediction_valid, prediction_data,
             qerr_ready, xhat_ready,
      input  x_ready, prediction_ready, qerr_valid, qerr_data, qerr_last,
             xhat_valid, xhat_data
   );

   modport slave (
      input  quant_shift, x_valid, x_data, prediction_valid, prediction_data,
             qerr_ready, xhat_ready,
      output x_ready, prediction_ready, qerr_valid, qerr_data, qerr_last,
             xhat_valid, xhat_data
   );
endinterface

// File: rtl/nthband_error_quantizer.sv
// Joins raw samples with predictions, quantizes the prediction error with a per-block shift,
// and forks the quantized error (to the coder) and the reconstructed sample (to the predictor).
module nthband_error_quantizer #(
   parameter int DATA_WIDTH     = 16,
   parameter int BLOCK_SIZE_LOG = 8,
   parameter int SHIFT_WIDTH    = 4
) (
   input logic                   clk,
   input logic                   rst,
   nthband_error_quantizer_if.slave bus
);
   localparam int EW = DATA_WIDTH + 2;
   localparam int RW = DATA_WIDTH + 3;

   // Round half away from zero: sign(e) * ((|e| + 2^(s-1)) >> s); s == 0 passes e through.
   function automatic logic signed [EW-1:0] round_err(input logic signed [EW-1:0] e,
                                                      input logic [SHIFT_WIDTH-1:0] s);
      logic [EW-1:0]        mag;
      logic [EW:0]          sum;
      logic [EW-1:0]        rq;
      logic signed [EW-1:0] res;
      mag = e[EW-1] ? EW'(-e) : EW'(e);
      sum = {1'b0, mag} + ((EW+1)'(1) << (s - SHIFT_WIDTH'(1)));
      rq  = EW'(sum >> s);
      if (s == '0)
         res = e;
      else if (e[EW-1])
         res = -$signed(rq);
      else
         res = $signed(rq);
      return res;
   endfunction

   function automatic logic [DATA_WIDTH-1:0] sat_rec(input logic signed [RW-1:0] v);
      logic [DATA_WIDTH-1:0] res;
      if (v[RW-1])
         res = '0;
      else if (|v[RW-2:DATA_WIDTH])
         res = '1;
      else
         res = v[DATA_WIDTH-1:0];
      return res;
   endfunction

   logic                          vld_p1, qp, xp;
   logic                          b_free, a_adv, a_free, join_p0;
   logic [BLOCK_SIZE_LOG-1:0]     cnt;
   logic [SHIFT_WIDTH-1:0]        shift_lat, shift_p0, shift_p1;
   logic signed [EW-1:0]          x_p0, pred_ext_p0, e_p0, e_p1, q_p1, q_p2;
   logic signed [DATA_WIDTH:0]    pred_p1;
   logic                          last_p1, last_p2;
   logic [DATA_WIDTH-1:0]         rec_p1, rec_p2;

   // Stage p0: join and flow control; reset forces the inputs not-ready
   assign b_free  = (!qp || bus.qerr_ready) && (!xp || bus.xhat_ready);
   assign a_adv   = vld_p1 && b_free;
   assign a_free  = !rst && (!vld_p1 || a_adv);
   assign join_p0 = bus.x_valid && bus.prediction_valid && a_free;

   assign bus.x_ready          = bus.prediction_valid && a_free;
   assign bus.prediction_ready = bus.x_valid && a_free;

   assign shift_p0    = (cnt == '0) ? bus.quant_shift : shift_lat;
   assign x_p0        = $signed({2'b00, bus.x_data});
   assign pred_ext_p0 = EW'(bus.prediction_data);
   assign e_p0        = x_p0 - pred_ext_p0;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         vld_p1    <= 1'b0;
         cnt       <= '0;
         shift_lat <= '0;
         qp        <= 1'b0;
         xp        <= 1'b0;
      end else begin
         if (a_free)
            vld_p1 <= join_p0;
         if (join_p0) begin
            cnt <= cnt + BLOCK_SIZE_LOG'(1);
            if (cnt == '0)
               shift_lat <= bus.quant_shift;
         end
         if (a_adv) begin
            qp <= 1'b1;
            xp <= 1'b1;
         end else begin
            if (bus.qerr_ready) qp <= 1'b0;
            if (bus.xhat_ready) xp <= 1'b0;
         end
      end
   end

   // Stage p1: error, prediction and effective shift
   always_ff @(posedge clk) begin
      if (join_p0) begin
         e_p1     <= e_p0;
         pred_p1  <= bus.prediction_data;
         shift_p1 <= shift_p0;
         last_p1  <= (cnt == '1);
      end
   end

   assign q_p1   = round_err(e_p1, shift_p1);
   assign rec_p1 = sat_rec(RW'(pred_p1) + (RW'(q_p1) <<< shift_p1));

   // Stage p2: output registers held until each consumer has taken its copy
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         q_p2    <= '0;
         rec_p2  <= '0;
         last_p2 <= 1'b0;
      end else if (a_adv) begin
         q_p2    <= q_p1;
         rec_p2  <= rec_p1;
         last_p2 <= last_p1;
      end
   end

   assign bus.qerr_valid = qp;
   assign bus.qerr_data  = q_p2;
   assign bus.qerr_last  = last_p2;
   assign bus.xhat_valid = xp;
   assign bus.xhat_data  = rec_p2;
endmodule

// File: tb/tb_nthband_error_quantizer.sv
// Randomized bench for nthband_error_quantizer against an integer-arithmetic block model,
// plus directed rounding/clamp cases, streaming, shift latch, backpressure and mid-block reset.
module tb_nthband_error_quantizer;
   localparam int DW = 16;
   localparam int BL = 256;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   nthband_error_quantizer_if #(.DATA_WIDTH(DW), .SHIFT_WIDTH(4)) bus ();

   nthband_error_quantizer #(.DATA_WIDTH(DW), .BLOCK_SIZE_LOG(8), .SHIFT_WIDTH(4)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   typedef struct {
      int q;
      int rec;
      int last;
      int cyc;
   } exp_t;

   exp_t qexp[$];
   exp_t xexp[$];
   int   xs[$];
   int   ps[$];

   int checks = 0;
   int errors = 0;
   int m_cnt, m_shift, cyc;
   int ix, ip, joins, out_idx, last_cnt, last_pos;
   int pv, pr, sh_a, sh_b, sh_sw;
   bit full_rate, x_pend, p_pend, q_hold, x_hold;
   int q_prev, x_prev, q_got_last, x_got_last, used;

   task automatic check(input string tag, input int got, input int exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   // Block model: counter, per-block shift, integer rounding and clamping
   function automatic void model_push(input int x, input int p, input int qs);
      exp_t t;
      int s, e, mag, r, q, rec;
      if (m_cnt == 0) m_shift = qs;
      s = m_shift;
      e = x - p;
      if (s == 0) q = e;
      else begin
         mag = (e < 0) ? -e : e;
         r   = (mag + (1 << (s - 1))) / (1 << s);
         q   = (e < 0) ? -r : r;
      end
      rec = p + q * (1 << s);
      if (rec < 0) rec = 0;
      if (rec > 65535) rec = 65535;
      t.q = q; t.rec = rec; t.last = (m_cnt == BL - 1) ? 1 : 0; t.cyc = cyc;
      m_cnt = (m_cnt + 1) % BL;
      qexp.push_back(t);
      xexp.push_back(t);
   endfunction

   task automatic step();
      exp_t t;
      int got;
      @(negedge clk);
      if (!x_pend && ix < xs.size() && $urandom_range(0, 99) < pv) x_pend = 1'b1;
      if (!p_pend && ip < ps.size() && $urandom_range(0, 99) < pv) p_pend = 1'b1;
      bus.x_valid          = x_pend;
      bus.x_data           = x_pend ? 16'(xs[ix]) : 16'h0;
      bus.prediction_valid = p_pend;
      bus.prediction_data  = p_pend ? 17'(ps[ip]) : 17'h0;
      bus.quant_shift      = 4'((joins < sh_sw) ? sh_a : sh_b);
      bus.qerr_ready       = ($urandom_range(0, 99) < pr);
      bus.xhat_ready       = ($urandom_range(0, 99) < pr);
      #1;
      if (q_hold) begin
         check("qerr_hold_valid", int'(bus.qerr_valid), 1);
         got = bus.qerr_data;
         check("qerr_hold_data", got, q_prev);
      end
      if (x_hold) begin
         check("xhat_hold_valid", int'(bus.xhat_valid), 1);
         check("xhat_hold_data", int'(bus.xhat_data), x_prev);
      end
      check("join_pair", int'(bus.x_valid && bus.x_ready),
            int'(bus.prediction_valid && bus.prediction_ready));
      if (bus.x_valid && bus.x_ready) begin
         model_push(xs[ix], ps[ip], int'(bus.quant_shift));
         ix++; ip++; joins++;
         x_pend = 1'b0; p_pend = 1'b0;
      end
      if (bus.qerr_valid && bus.qerr_ready) begin
         got = bus.qerr_data;
         if (qexp.size() == 0) check("qerr_extra", 1, 0);
         else begin
            t = qexp.pop_front();
            check("qerr", got, t.q);
            check("qerr_last", int'(bus.qerr_last), t.last);
            if (full_rate) check("latency", cyc - t.cyc, 2);
            if (bus.qerr_last) begin
               last_cnt++;
               last_pos = out_idx;
            end
            out_idx++;
            q_got_last = got;
         end
      end
      if (bus.xhat_valid && bus.xhat_ready) begin
         if (xexp.size() == 0) check("xhat_extra", 1, 0);
         else begin
            t = xexp.pop_front();
            check("xhat", int'(bus.xhat_data), t.rec);
            x_got_last = int'(bus.xhat_data);
         end
      end
      q_hold = bus.qerr_valid && !bus.qerr_ready;
      q_prev = bus.qerr_data;
      x_hold = bus.xhat_valid && !bus.xhat_ready;
      x_prev = int'(bus.xhat_data);
      cyc++;
   endtask

   task automatic run_phase(input int pvv, input int prv, input bit fr, input int stop);
      int bound;
      pv = pvv; pr = prv; full_rate = fr;
      ix = 0; ip = 0; joins = 0; out_idx = 0; last_cnt = 0; last_pos = -1;
      q_got_last = -999999; x_got_last = -999999;
      used = 0;
      bound = xs.size() * 20 + 100;
      while (1) begin
         step();
         used++;
         if (stop > 0 && joins >= stop) break;
         if (ix == xs.size() && qexp.size() == 0 && xexp.size() == 0) break;
         if (used >= bound) begin
            check("timeout", 0, 1);
            break;
         end
      end
   endtask

   task automatic hard_reset();
      @(negedge clk);
      #2;
      rst = 1'b1;
      #1;
      check("rst_qerr_valid", int'(bus.qerr_valid), 0);
      check("rst_xhat_valid", int'(bus.xhat_valid), 0);
      bus.x_valid = 1'b0; bus.prediction_valid = 1'b0;
      bus.qerr_ready = 1'b0; bus.xhat_ready = 1'b0;
      m_cnt = 0; m_shift = 0;
      qexp.delete(); xexp.delete();
      x_pend = 1'b0; p_pend = 1'b0; q_hold = 1'b0; x_hold = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic fill_random(input int n);
      int x, p;
      xs.delete(); ps.delete();
      for (int i = 0; i < n; i++) begin
         x = int'($urandom_range(0, 65535));
         if ($urandom_range(0, 1) == 0) begin
            p = x + int'($urandom_range(0, 2000)) - 1000;
            if (p < -65536) p = -65536;
            if (p > 65535) p = 65535;
         end else
            p = int'($urandom_range(0, 131071)) - 65536;
         xs.push_back(x);
         ps.push_back(p);
      end
   endtask

   task automatic directed(input string tag, input int x, input int p, input int s,
                           input int eq, input int ex);
      hard_reset();
      xs.delete(); ps.delete();
      xs.push_back(x); ps.push_back(p);
      sh_a = s; sh_b = s; sh_sw = 0;
      run_phase(100, 100, 1'b0, 0);
      check({tag, "_qerr"}, q_got_last, eq);
      check({tag, "_xhat"}, x_got_last, ex);
   endtask

   initial begin
      rst = 1'b1;
      bus.quant_shift = '0;
      bus.x_valid = 1'b1; bus.x_data = '0;
      bus.prediction_valid = 1'b1; bus.prediction_data = '0;
      bus.qerr_ready = 1'b1; bus.xhat_ready = 1'b1;
      m_cnt = 0; m_shift = 0; cyc = 0;
      x_pend = 1'b0; p_pend = 1'b0; q_hold = 1'b0; x_hold = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("reset_qerr_valid", int'(bus.qerr_valid), 0);
      check("reset_xhat_valid", int'(bus.xhat_valid), 0);
      check("reset_qerr_data", int'(bus.qerr_data), 0);
      check("reset_xhat_data", int'(bus.xhat_data), 0);
      check("reset_qerr_last", int'(bus.qerr_last), 0);
      check("reset_x_ready", int'(bus.x_ready), 0);
      check("reset_pred_ready", int'(bus.prediction_ready), 0);
      bus.x_valid = 1'b0; bus.prediction_valid = 1'b0;
      rst = 1'b0;

      directed("round_s0", 1000, 990, 0, 10, 1000);
      directed("round_s2", 1000, 990, 2, 3, 1002);
      directed("round_neg", 990, 1000, 2, -3, 988);
      directed("clamp_low", 0, -100, 4, 6, 0);
      directed("clamp_high", 65535, 65530, 3, 1, 65535);

      // Two full blocks at full rate
      hard_reset();
      fill_random(2 * BL);
      sh_a = int'($urandom_range(0, 15)); sh_b = sh_a; sh_sw = 0;
      run_phase(100, 100, 1'b1, 0);
      check("stream_cycles", used, 2 * BL + 2);
      check("stream_last_count", last_cnt, 2);
      check("stream_last_pos", last_pos, 2 * BL - 1);

      // Shift change mid-block applies only from the next block
      hard_reset();
      fill_random(2 * BL);
      sh_a = 2; sh_b = 5; sh_sw = 100;
      run_phase(100, 100, 1'b1, 0);
      check("latch_last_count", last_cnt, 2);

      // Random valids and independent random readies
      hard_reset();
      fill_random(1500);
      sh_a = int'($urandom_range(0, 15)); sh_b = int'($urandom_range(0, 15)); sh_sw = 700;
      run_phase(60, 50, 1'b0, 0);
      check("bp_last_count", last_cnt, 5);

      // Reset with samples in flight, then a clean block
      hard_reset();
      fill_random(BL);
      sh_a = 3; sh_b = 3; sh_sw = 0;
      run_phase(80, 30, 1'b0, 37);
      hard_reset();
      fill_random(BL);
      sh_a = 1; sh_b = 1; sh_sw = 0;
      run_phase(100, 100, 1'b1, 0);
      check("post_rst_last_count", last_cnt, 1);
      check("post_rst_last_pos", last_pos, BL - 1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/nthband_error_quantizer.md
# nthband_error_quantizer

Downstream neighbour of `nthband_predictor` in the LCPLC nth-band datapath. It joins each raw sample with its prediction and computes the prediction error. It quantizes that error with a per-block shift and emits the quantized error, with a last-of-block flag, toward the entropy coder. It also reconstructs the decoded sample `xhat` and forks it back as the predictor input for the next band.

## Interface
- `DATA_WIDTH`, 16, raw sample width (unsigned).
- `BLOCK_SIZE_LOG`, 8, log2 of samples per block.
- `SHIFT_WIDTH`, 4, width of the quantization shift.

- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `quant_shift`  in  SHIFT_WIDTH  quantization shift `s`, sampled at each block's first sample.
- `x_valid` / `x_ready` / `x_data`  in/out/in  1/1/DATA_WIDTH  raw sample stream.
- `prediction_valid` / `prediction_ready` / `prediction_data`  in/out/in  1/1/DATA_WIDTH+1  signed prediction stream.
- `qerr_valid` / `qerr_ready` / `qerr_data` / `qerr_last`  out/in/out/out  1/1/DATA_WIDTH+2/1  signed quantized error, with last-of-block flag.
- `xhat_valid` / `xhat_ready` / `xhat_data`  out/in/out  1/1/DATA_WIDTH  reconstructed sample.

## Operation
- **Join.**
  - Fires when `x_valid && prediction_valid && stageA_free`.
  - `x_ready = prediction_valid && stageA_free`; `prediction_ready = x_valid && stageA_free`.
  - Neither input is consumed alone.
- **Stage A (register).**
  - `e = x - pred`, signed, DATA_WIDTH+2 bits; range [-(2^DW-1), 2^(DW+1)-1], no overflow.
  - Registers `pred` and the effective shift.
  - Registers `last = (cnt == 2^BLOCK_SIZE_LOG-1)`.
- **Shift latch.** When the join fires with `cnt == 0`, `quant_shift` is latched and applies to the whole block. Otherwise the latched value is used.
- **Stage B (register).**
  - If `s == 0`: `q = e`.
  - Else: `q = sign(e) * ((|e| + 2^(s-1)) >> s)`, i.e. round half away from zero.
  - `rec = pred + (q << s)`, computed at DATA_WIDTH+3 bits, clamped to [0, 2^DATA_WIDTH-1].
  - `qerr_data = q`, `xhat_data = rec`, `qerr_last = last`.
- **Fork at stage B output.**
  - Independent pending bits `qp` and `xp`, both set when stage B loads.
  - `qp` clears on `qerr_valid && qerr_ready`; `xp` clears on `xhat_valid && xhat_ready`.
  - `qerr_valid = qp`, `xhat_valid = xp`.
  - Stage B is free when both bits clear, or when every remaining set bit is handshaking this cycle.
- **Pipeline flow.**
  - Stage A advances into B when B is free, or frees this cycle.
  - `stageA_free = !A_valid || A_advances`, giving a full-throughput bubble-free pipeline.
- **Sample counter.**
  - `cnt` is BLOCK_SIZE_LOG bits and increments on each join.
  - It wraps from 2^BLOCK_SIZE_LOG-1 to 0.
  - No per-band state beyond the counter.

## Timing
- **Reset values.**
  - All valids 0, `qp = xp = 0`, `cnt = 0`, latched shift 0.
  - `qerr_data`, `xhat_data` = 0; `qerr_last` = 0.
  - `x_ready` and `prediction_ready` are 0 because `stageA_free` is gated by reset.
- **Latency.** A join at edge N puts valid outputs on the cycle after edge N+1, i.e. 2 cycles. Throughput is 1 sample/clock with both readies high.
- **Ready-side timing.**
  - Ready paths are combinational from downstream readies through the free logic. There are no combinational valid→valid paths.
  - An output asserting valid holds data and valid stable until its handshake.
  - One consumer may accept several cycles before the other; that output does not repeat.
- **Simultaneous events.**
  - Join and stage-B load in the same cycle are legal.
  - A counter wrap and a shift latch for the next block in consecutive joins are legal.
- **Boundary conditions.**
  - Inputs are not required to arrive together; whichever arrives first is held by its source.
  - `quant_shift` changes mid-block are ignored until the next `cnt == 0` join.
  - Shift values above DATA_WIDTH+1 are out of contract.
- **Reset mid-operation.** Asserting `rst` asynchronously clears all pipeline contents, pending bits and the counter. In-flight samples are discarded and no partial block is flagged.

## Test plan
- **Rounding.** `s = 0`, x=1000, pred=990 → qerr=10, xhat=1000. `s = 2`, same inputs → qerr=3, xhat=1002. `s = 2`, x=990, pred=1000 → qerr=-3, xhat=988.
- **Clamp.** `s = 4`, x=0, pred=-100 → qerr=6, xhat=0 (low clamp). `s = 3`, x=65535, pred=65530 → qerr=1, xhat=65535 (high clamp).
- **Streaming.** 256 samples with all valids/readies high → outputs every cycle after 2-cycle latency. `qerr_last` high only on sample 255. Counter wraps and the next block starts clean.
- **Shift latch.** `quant_shift` = 2 at sample 0, switched to 5 at sample 100 → whole block uses s=2. The next block's first sample latches 5.
- **Independent backpressure.**
  - Random independent `qerr_ready`/`xhat_ready` and random input valids.
  - Both output sequences match the golden model exactly once each.
  - No data changes while valid && !ready.
  - `x_ready`/`prediction_ready` never consume one input alone.
- **Reset mid-block.** Assert `rst` after sample 37 with outputs pending → all valids drop at once. After release, the first output has `cnt` restarted (last on its 256th sample).
